// File: rtl/regbank_pkg.sv
// Shared types and helpers for the reset-vector register bank write controller.
//   state_e  : controller FSM state (idle / clear sequence running).
//   id_width : width of a requester index; never narrower than one bit.
package regbank_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_rr_write_ctrl_if.sv
// Requester-facing bus of the register bank write controller.
//   master : requester side; drives req_valid/req_addr/req_data/soft_clr and
//            observes grants, completion pulses, busy and register contents.
//   slave  : controller side; the mirror image.
// Slice k of req_addr/req_data belongs to requester k.
interface regbank_rr_write_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned ID_W   = regbank_pkg::id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      soft_clr;
  logic                      busy;
  logic                      wr_done;
  logic [ID_W-1:0]           wr_done_id;
  logic                      wr_err;
  logic [DEPTH*WIDTH-1:0]    regs;

  modport master (
    output req_valid, req_addr, req_data, soft_clr,
    input  req_ready, busy, wr_done, wr_done_id, wr_err, regs
  );

  modport slave (
    input  req_valid, req_addr, req_data, soft_clr,
    output req_ready, busy, wr_done, wr_done_id, wr_err, regs
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rstn : clock, async active-low reset (pointer returns to 0).
//   req       : per-requester request vector.
//   advance   : a grant was taken this cycle; move pointer past the winner.
//   grant     : one-hot-or-zero grant, search starting at the pointer.
//   grant_id  : index of the granted requester (0 when nothing is granted).
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  int unsigned     idx;
  logic [ID_W-1:0] idx_w;
  logic            found;

  // Walk ptr, ptr+1, ... with explicit wrap so non-power-of-two counts work.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = idx[ID_W-1:0];
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regbank_rr_write_ctrl.sv
// Write controller for a small bank of reset-vector registers shared by
// NUM_REQ requesters. One write per cycle is granted round-robin; a soft
// clear walks the bank restoring RESET_VALUES one register per cycle while
// blocking writers.
//   clk, rstn : clock, async active-low reset.
//   bus       : slave modport carrying requests, grants, soft_clr, busy,
//               completion pulses (wr_done/wr_done_id/wr_err) and the flat
//               register contents.
module regbank_rr_write_ctrl
  import regbank_pkg::*;
#(
  parameter int unsigned            NUM_REQ      = 4,
  parameter int unsigned            WIDTH        = 32,
  parameter int unsigned            DEPTH        = 8,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALUES = '0
) (
  input logic                   clk,
  input logic                   rstn,
  regbank_rr_write_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned ID_W   = id_width(NUM_REQ);
  localparam logic [DEPTH-1:0][WIDTH-1:0] RstArr = RESET_VALUES;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic                        wr_done_q, wr_err_q;
  logic [ID_W-1:0]             wr_done_id_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               arb_en, we, clr_en, addr_oob;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (bus.req_valid),
    .advance  (we),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next state; a soft_clr seen during CLEAR restarts the walk at index 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      StIdle: begin
        if (bus.soft_clr) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        if (bus.soft_clr) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = StIdle;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        clr_idx_d = '0;
      end
    endcase
  end

  // Outputs; clear requests take priority over writes, and rstn gates
  // grants so nothing is handed out while reset is held.
  always_comb begin
    arb_en        = rstn && (state_q == StIdle) && !bus.soft_clr;
    bus.req_ready = grant & {NUM_REQ{arb_en}};
    we            = arb_en && (|bus.req_valid);
    clr_en        = (state_q == StClear);
    bus.busy      = (state_q == StClear);
  end

  assign wr_addr  = bus.req_addr[grant_id*ADDR_W +: ADDR_W];
  assign wr_data  = bus.req_data[grant_id*WIDTH +: WIDTH];
  // Extra MSB keeps the compare meaningful when DEPTH is a power of two.
  assign addr_oob = ({1'b0, wr_addr} >= (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q <= RstArr;
    end else begin
      if (clr_en) regs_q[clr_idx_q] <= RstArr[clr_idx_q];
      if (we && !addr_oob) regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_done_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_done_id_q <= '0;
    end else begin
      wr_done_q <= we;
      wr_err_q  <= we && addr_oob;
      if (we) wr_done_id_q <= grant_id;
    end
  end

  assign bus.wr_done    = wr_done_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.wr_done_id = wr_done_id_q;
  assign bus.regs       = regs_q;

endmodule

// File: tb/tb_regbank_rr_write_ctrl.sv
// Bench for regbank_rr_write_ctrl. DEPTH is 6 here: with a 3-bit address an
// out-of-range index (6, 7) is expressible, which it is not at DEPTH=8.
module tb_regbank_rr_write_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 6;
  localparam int unsigned ADDR_W  = 3;
  localparam logic [DEPTH*WIDTH-1:0] RV = {64'h0, 32'hDEAD_BEEF, 96'h0};

  logic clk = 1'b0;
  logic rstn;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  regbank_rr_write_ctrl_if #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH)
  ) bus ();

  regbank_rr_write_ctrl #(
    .NUM_REQ      (NUM_REQ),
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .RESET_VALUES (RV)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0]       m_regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] rv_vec;
  logic [DEPTH*WIDTH-1:0] exp_regs;
  logic [NUM_REQ-1:0]     exp_ready;
  int  m_ptr, m_idx, m_id, g, k, a;
  bit  m_clear, m_done, m_err;

  always @(negedge clk) begin
    rv_vec = RV;
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = rv_vec[i*WIDTH +: WIDTH];
      m_ptr = 0; m_idx = 0; m_id = 0;
      m_clear = 0; m_done = 0; m_err = 0;
    end
    // Who wins this cycle: first valid requester from the pointer, unless
    // clearing or a clear is being requested.
    g = -1;
    if (rstn && !m_clear && !bus.soft_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_ptr + i) % NUM_REQ;
        if (g < 0 && bus.req_valid[k]) g = k;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_regs[i*WIDTH +: WIDTH] = m_regs[i];

    check("m_ready", bus.req_ready, exp_ready);
    check("m_busy", bus.busy, m_clear);
    check("m_done", bus.wr_done, m_done);
    check("m_err", bus.wr_err, m_err);
    check("m_regs", bus.regs, exp_regs);
    if (m_done) check("m_id", bus.wr_done_id, m_id);

    // Effect of the coming rising edge.
    if (rstn) begin
      m_done = (g >= 0);
      m_err  = 0;
      if (g >= 0) begin
        a    = int'(bus.req_addr[g*ADDR_W +: ADDR_W]);
        m_id = g;
        if (a < DEPTH) m_regs[a] = bus.req_data[g*WIDTH +: WIDTH];
        else           m_err = 1;
        m_ptr = (g + 1) % NUM_REQ;
      end
      if (m_clear) begin
        m_regs[m_idx] = rv_vec[m_idx*WIDTH +: WIDTH];
        if (bus.soft_clr)          m_idx = 0;
        else if (m_idx == DEPTH-1) begin m_clear = 0; m_idx = 0; end
        else                       m_idx = m_idx + 1;
      end else if (bus.soft_clr) begin
        m_clear = 1;
        m_idx   = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [ADDR_W-1:0] ad, input logic [WIDTH-1:0] d);
    bus.req_addr[r*ADDR_W +: ADDR_W] = ad;
    bus.req_data[r*WIDTH +: WIDTH]   = d;
  endtask

  initial begin
    rstn          = 1'b0;
    bus.req_valid = '1;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.soft_clr  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_reg3", bus.regs[3*WIDTH +: WIDTH], 32'hDEAD_BEEF);
    check("rst_busy", bus.busy, 1'b0);
    step(); rstn = 1'b1; bus.req_valid = '0;
    step();

    // Three requesters held valid: grants 0, 1, 2 in turn
    set_req(0, 3'd1, 32'hAAAA_0001);
    set_req(1, 3'd2, 32'hBBBB_0002);
    set_req(2, 3'd3, 32'hCCCC_0003);
    bus.req_valid = 4'b0111;
    @(negedge clk); check("grant0", bus.req_ready, 4'b0001);
    step(); bus.req_valid = 4'b0110;
    @(negedge clk); check("grant1", bus.req_ready, 4'b0010);
    check("id0", bus.wr_done_id, 0);
    check("reg1_a", bus.regs[1*WIDTH +: WIDTH], 32'hAAAA_0001);
    step(); bus.req_valid = 4'b0100;
    @(negedge clk); check("grant2", bus.req_ready, 4'b0100);
    check("id1", bus.wr_done_id, 1);
    step(); bus.req_valid = 4'b0000;
    @(negedge clk); check("id2", bus.wr_done_id, 2);
    check("reg2_b", bus.regs[2*WIDTH +: WIDTH], 32'hBBBB_0002);
    step();
    @(negedge clk); check("reg3_c", bus.regs[3*WIDTH +: WIDTH], 32'hCCCC_0003);

    // Requester 3, then pointer wraps so 0 beats 3
    set_req(3, 3'd5, 32'hDDDD_0005);
    bus.req_valid = 4'b1000;
    @(negedge clk); check("grant3", bus.req_ready, 4'b1000);
    step();
    set_req(0, 3'd0, 32'hEEEE_0000);
    set_req(3, 3'd4, 32'hFFFF_0004);
    bus.req_valid = 4'b1001;
    @(negedge clk); check("wrap_grant0", bus.req_ready, 4'b0001);
    step(); bus.req_valid = 4'b1000;
    @(negedge clk); check("then_grant3", bus.req_ready, 4'b1000);
    step(); bus.req_valid = 4'b0000;

    // Out-of-range address
    set_req(0, 3'd7, 32'h1234_5678);
    bus.req_valid = 4'b0001;
    @(negedge clk); check("oob_ready", bus.req_ready, 4'b0001);
    step(); bus.req_valid = 4'b0000;
    @(negedge clk); check("oob_err", bus.wr_err, 1'b1);
    check("oob_done", bus.wr_done, 1'b1);
    step();
    @(negedge clk); check("oob_err_gone", bus.wr_err, 1'b0);

    // soft_clr with requester 1 pending
    set_req(1, 3'd0, 32'h0000_0055);
    bus.req_valid = 4'b0010;
    bus.soft_clr  = 1'b1;
    @(negedge clk); check("clr_blocks", bus.req_ready, 4'b0000);
    step(); bus.soft_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); check("clr_busy", bus.busy, 1'b1);
      check("clr_noready", bus.req_ready, 4'b0000);
      step();
    end
    @(negedge clk); check("clr_end_busy", bus.busy, 1'b0);
    check("clr_end_grant1", bus.req_ready, 4'b0010);
    step(); bus.req_valid = 4'b0000;
    @(negedge clk); check("post_reg0", bus.regs[0*WIDTH +: WIDTH], 32'h0000_0055);
    check("post_reg3", bus.regs[3*WIDTH +: WIDTH], 32'hDEAD_BEEF);

    // Restart mid-clear, then async reset mid-clear
    set_req(0, 3'd5, 32'h0000_0077);
    bus.req_valid = 4'b0001;
    step(); bus.req_valid = 4'b0000; bus.soft_clr = 1'b1;
    step(); bus.soft_clr = 1'b0;
    step(); step(); step(); step();
    bus.soft_clr = 1'b1;
    @(negedge clk); check("restart_busy", bus.busy, 1'b1);
    step(); bus.soft_clr = 1'b0;
    step(); step();
    @(negedge clk); check("untouched_reg5", bus.regs[5*WIDTH +: WIDTH], 32'h0000_0077);
    step(); rstn = 1'b0; bus.req_valid = 4'b0001;
    @(negedge clk); check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_regs", bus.regs, RV);
    check("mid_rst_ready", bus.req_ready, 4'b0000);
    step(); rstn = 1'b1; bus.req_valid = 4'b0000;
    @(negedge clk); check("after_rst_busy", bus.busy, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
